// File: rtl/hazard_stall_unit_pkg.sv
// hazard_pkg: shared types and constants for the hazard stall unit
package hazard_pkg;

    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         MULT_CYCLES_DEF = 4;
    localparam int         DIV_CYCLES_DEF  = 32;

    // True when the ID instruction reads a nonzero register that matches addr
    function automatic logic reads_reg(input logic use_rs, input logic [4:0] rs,
                                       input logic use_rt, input logic [4:0] rt,
                                       input logic [4:0] addr);
        return (addr != REG_ZERO) && ((use_rs && rs == addr) || (use_rt && rt == addr));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline-side signals of the hazard stall unit (stats outputs under HAZARD_STATS_EN)
interface hazard_stall_unit_if;

    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        use_rs_id;
    logic        use_rt_id;
    logic        branch_id;
    logic        mfhilo_id;
    logic        md_id;
    logic        reg_write_ex;
    logic        mem_read_ex;
    logic [4:0]  reg_w_addr_ex;
    logic        mem_read_mem;
    logic [4:0]  reg_w_addr_mem;
    logic        md_start_ex;
    logic        md_is_div_ex;
    logic        stall_pc;
    logic        stall_if_id;
    logic        bubble_id_ex;
    logic        md_busy;
    logic        md_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] load_use_cnt;
    logic [31:0] md_stall_cnt;
`endif

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, branch_id, mfhilo_id, md_id,
               reg_write_ex, mem_read_ex, reg_w_addr_ex, mem_read_mem, reg_w_addr_mem,
               md_start_ex, md_is_div_ex,
        input  stall_pc, stall_if_id, bubble_id_ex, md_busy, md_done
`ifdef HAZARD_STATS_EN
        , input stall_cycles, load_use_cnt, md_stall_cnt
`endif
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, branch_id, mfhilo_id, md_id,
               reg_write_ex, mem_read_ex, reg_w_addr_ex, mem_read_mem, reg_w_addr_mem,
               md_start_ex, md_is_div_ex,
        output stall_pc, stall_if_id, bubble_id_ex, md_busy, md_done
`ifdef HAZARD_STATS_EN
        , output stall_cycles, load_use_cnt, md_stall_cnt
`endif
    );

endinterface

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// md_busy_tracker: mult/div busy FSM with latency down-counter and last-cycle done pulse
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy,
    output logic o_done
);

    md_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_done;

    // Next state: a start while busy is ignored because ID stalls it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == IDLE) begin
            if (i_start) begin
                w_state_nxt = BUSY;
                w_cnt_nxt   = i_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            end
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end else begin
            w_state_nxt = IDLE;
        end
    end

    // State, counter and done flop; done is set for the BUSY cycle whose count is zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= (w_state_nxt == BUSY) && (w_cnt_nxt == '0);
        end
    end

    assign o_busy = (r_state == BUSY);
    assign o_done = r_done;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage load-use / branch-operand / mult-div stall generator (optional HAZARD_STATS_EN counters)
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 6
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave bus
);

    logic w_rd_ex, w_rd_mem, w_load_use, w_br_haz, w_md_haz, w_stall;
    logic w_md_busy, w_md_done;

    md_busy_tracker #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk     (clk),
        .rst     (rst),
        .i_start (bus.md_start_ex),
        .i_is_div(bus.md_is_div_ex),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done)
    );

    assign w_rd_ex    = reads_reg(bus.use_rs_id, bus.rs_id, bus.use_rt_id, bus.rt_id, bus.reg_w_addr_ex);
    assign w_rd_mem   = reads_reg(bus.use_rs_id, bus.rs_id, bus.use_rt_id, bus.rt_id, bus.reg_w_addr_mem);
    assign w_load_use = bus.mem_read_ex && w_rd_ex;
    assign w_br_haz   = bus.branch_id && ((bus.reg_write_ex && w_rd_ex) || (bus.mem_read_mem && w_rd_mem));
    assign w_md_haz   = (bus.mfhilo_id || bus.md_id) && (w_md_busy || bus.md_start_ex);
    assign w_stall    = w_load_use || w_br_haz || w_md_haz;

    assign bus.stall_pc     = w_stall;
    assign bus.stall_if_id  = w_stall;
    assign bus.bubble_id_ex = w_stall;
    assign bus.md_busy      = w_md_busy;
    assign bus.md_done      = w_md_done;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles, r_load_use_cnt, r_md_stall_cnt;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_load_use_cnt <= '0;
            r_md_stall_cnt <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + {31'd0, w_stall    && !(&r_stall_cycles)};
            r_load_use_cnt <= r_load_use_cnt + {31'd0, w_load_use && !(&r_load_use_cnt)};
            r_md_stall_cnt <= r_md_stall_cnt + {31'd0, w_md_haz   && !(&r_md_stall_cnt)};
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.load_use_cnt = r_load_use_cnt;
    assign bus.md_stall_cnt = r_md_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench with directed and random stimulus against an interval-based reference model
module tb_hazard_stall_unit;
    import hazard_pkg::*;

    localparam int ML = 4;
    localparam int DL = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_stall_unit_if bus();

    hazard_stall_unit #(.MULT_CYCLES(ML), .DIV_CYCLES(DL), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt, wex, wmem;
        logic       urs, urt, br, mfh, md, rwe, mre, mrm, st, dv;
    } stim_t;

    typedef struct {
        logic        stall, busy, done, start;
        int unsigned sc, lu, ms;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lo = 0;
    int          hi = -1;
    int unsigned c_st = 0, c_lu = 0, c_ms = 0;

    function automatic bit rd(stim_t s, logic [4:0] a);
        return a != 0 && ((s.urs && s.rs == a) || (s.urt && s.rt == a));
    endfunction

    function automatic bit model_busy();
        return cyc >= lo && cyc <= hi;
    endfunction

    // Drive one cycle and push the expected response; the md unit is modelled as a busy interval [lo,hi]
    task automatic step(input stim_t s);
        exp_t e;
        bit   busy, lu, br, mh;
        @(posedge clk);
        #1;
        rst                = s.rst;
        bus.rs_id          = s.rs;
        bus.rt_id          = s.rt;
        bus.use_rs_id      = s.urs;
        bus.use_rt_id      = s.urt;
        bus.branch_id      = s.br;
        bus.mfhilo_id      = s.mfh;
        bus.md_id          = s.md;
        bus.reg_write_ex   = s.rwe;
        bus.mem_read_ex    = s.mre;
        bus.reg_w_addr_ex  = s.wex;
        bus.mem_read_mem   = s.mrm;
        bus.reg_w_addr_mem = s.wmem;
        bus.md_start_ex    = s.st;
        bus.md_is_div_ex   = s.dv;
        busy = model_busy();
        lu   = s.mre && rd(s, s.wex);
        br   = s.br && ((s.rwe && rd(s, s.wex)) || (s.mrm && rd(s, s.wmem)));
        mh   = (s.mfh || s.md) && (busy || s.st);
        e.stall = lu || br || mh;
        e.busy  = busy;
        e.done  = busy && cyc == hi;
        e.start = s.st;
        e.sc    = c_st;
        e.lu    = c_lu;
        e.ms    = c_ms;
        q.push_back(e);
        if (s.rst) begin
            lo   = 0;
            hi   = -1;
            c_st = 0;
            c_lu = 0;
            c_ms = 0;
        end else begin
            if (s.st && !busy) begin
                lo = cyc + 1;
                hi = cyc + (s.dv ? DL : ML);
            end
            c_st += 32'(e.stall);
            c_lu += 32'(lu);
            c_ms += 32'(mh);
        end
        cyc++;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", n, cyc, a, x);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall_pc", 32'(bus.stall_pc), 32'(e.stall));
            chk("stall_if_id", 32'(bus.stall_if_id), 32'(e.stall));
            chk("bubble_id_ex", 32'(bus.bubble_id_ex), 32'(e.stall));
            chk("md_busy", 32'(bus.md_busy), 32'(e.busy));
            chk("md_done", 32'(bus.md_done), 32'(e.done));
            if (e.start)
                chk("start_while_busy", 32'(bus.md_busy), 32'd0);
`ifdef HAZARD_STATS_EN
            chk("stall_cycles", bus.stall_cycles, e.sc);
            chk("load_use_cnt", bus.load_use_cnt, e.lu);
            chk("md_stall_cnt", bus.md_stall_cnt, e.ms);
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        s = '{default: 0};
        rst = 1'b1;
        bus.rs_id = 0; bus.rt_id = 0; bus.use_rs_id = 0; bus.use_rt_id = 0;
        bus.branch_id = 0; bus.mfhilo_id = 0; bus.md_id = 0; bus.reg_write_ex = 0;
        bus.mem_read_ex = 0; bus.reg_w_addr_ex = 0; bus.mem_read_mem = 0;
        bus.reg_w_addr_mem = 0; bus.md_start_ex = 0; bus.md_is_div_ex = 0;
        @(posedge clk);
        s.rst = 1; step(s); step(s);
        s = '{default: 0};
        // load-use on rt, then EX destination r0
        s.mre = 1; s.wex = 5; s.urt = 1; s.rt = 5; step(s); step(s); step(s);
        s.wex = 0; step(s);
        // ID-branch operand hazards
        s = '{default: 0}; s.br = 1; s.urs = 1; s.rs = 8;
        s.rwe = 1; s.wex = 8; step(s);
        s.rwe = 0; s.wex = 0; s.mrm = 1; s.wmem = 8; step(s);
        s.mrm = 0; step(s);
        // mult then held mfhi: start cycle stalls nothing, mfhi waits four cycles
        s = '{default: 0}; s.st = 1; step(s);
        s.st = 0; s.mfh = 1; repeat (5) step(s);
        // mult with mfhi already in ID at issue
        s = '{default: 0}; s.st = 1; s.mfh = 1; step(s);
        s.st = 0; repeat (6) step(s);
        // div with back-to-back md op
        s = '{default: 0}; s.st = 1; s.dv = 1; step(s);
        s.st = 0; s.dv = 0; s.md = 1; repeat (DL + 1) step(s);
        s = '{default: 0}; step(s);
        // reset mid div
        s.st = 1; s.dv = 1; step(s);
        s = '{default: 0}; repeat (9) step(s);
        s.rst = 1; step(s);
        s.rst = 0; s.mfh = 1; repeat (DL + 2) step(s);
        // latency-one style back-to-back issue right after completion
        s = '{default: 0}; s.st = 1; step(s);
        s.st = 0; repeat (ML) step(s);
        s.st = 1; step(s);
        s.st = 0; repeat (ML + 1) step(s);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 99) == 0);
            s.rs   = 5'($urandom_range(0, 3));
            s.rt   = 5'($urandom_range(0, 3));
            s.wex  = 5'($urandom_range(0, 3));
            s.wmem = 5'($urandom_range(0, 3));
            s.urs  = $urandom_range(0, 1) == 1;
            s.urt  = $urandom_range(0, 1) == 1;
            s.br   = $urandom_range(0, 2) == 0;
            s.mfh  = $urandom_range(0, 5) == 0;
            s.md   = $urandom_range(0, 7) == 0;
            s.rwe  = $urandom_range(0, 1) == 1;
            s.mre  = $urandom_range(0, 2) == 0;
            s.mrm  = $urandom_range(0, 2) == 0;
            s.st   = !model_busy() && $urandom_range(0, 3) == 0;
            s.dv   = $urandom_range(0, 4) == 0;
            step(s);
        end
        s = '{default: 0}; step(s);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard detector. It covers the hazards that EX/MEM forwarding cannot resolve; together with the EX forwarding unit it forms the full RAW-hazard scheme.
- Detects load-use and ID-branch operand hazards, and tracks the multi-cycle mult/div unit so that HI/LO readers and new mult/div ops wait.
- Drives PC/IF-ID hold and the ID/EX bubble.

Parameters:
- MULT_CYCLES, 4: cycles the mult unit is busy after issue (>=1).
- DIV_CYCLES, 32: cycles the div unit is busy after issue (>=1).
- CNT_W, 6: busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs_id, rt_id  in  5  source register numbers of the instruction in ID.
- use_rs_id, use_rt_id  in  1  the ID instruction actually reads rs / rt.
- branch_id  in  1  the ID instruction is a branch compared in ID.
- mfhilo_id  in  1  the ID instruction reads HI/LO (mfhi/mflo).
- md_id  in  1  the ID instruction is mult/multu/div/divu.
- reg_write_ex, mem_read_ex  in  1  write-enable and load flag of the instruction in EX.
- reg_w_addr_ex  in  5  destination register of the instruction in EX.
- mem_read_mem  in  1  the instruction in MEM is a load.
- reg_w_addr_mem  in  5  destination register of the instruction in MEM.
- md_start_ex  in  1  a mult/div is issuing from EX this cycle.
- md_is_div_ex  in  1  1 = div latency, 0 = mult latency.
- stall_pc, stall_if_id  out  1  hold the PC and the IF/ID register.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- md_busy  out  1  the mult/div unit is busy (registered).
- md_done  out  1  one-cycle pulse on the last busy cycle (registered).

Behaviour:
- Register 0 never causes a hazard; every address match also requires addr != 0.
- Match terms: mrs = use_rs_id && rs_id == addr; mrt = use_rt_id && rt_id == addr.
- load_use = mem_read_ex && (mrs||mrt) against reg_w_addr_ex.
- br_haz = branch_id && ((reg_write_ex && (mrs||mrt) vs reg_w_addr_ex) || (mem_read_mem && (mrs||mrt) vs reg_w_addr_mem)).
- md_haz = (mfhilo_id || md_id) && (md_busy || md_start_ex).
- stall = load_use | br_haz | md_haz. stall_pc = stall_if_id = bubble_id_ex = stall, combinational with zero latency.
- FSM states: IDLE and BUSY.
  - IDLE: md_start_ex loads cnt with (md_is_div_ex ? DIV_CYCLES : MULT_CYCLES) - 1 and moves to BUSY.
  - BUSY: cnt != 0 decrements cnt. cnt == 0 asserts md_done for that cycle and returns to IDLE next cycle.
- md_busy = (state == BUSY).
- Timing example: mult issued in EX at cycle T gives md_busy over T+1..T+MULT_CYCLES and md_done at T+MULT_CYCLES. A dependent mfhi in ID is released at T+MULT_CYCLES+1.
- Latency 1 edge case: with latency 1 the counter loads 0; BUSY lasts one cycle with md_done set.
- md_start_ex while BUSY is illegal, because md_id stalls it. RTL ignores it; the bench asserts it never occurs.
- Simultaneous hazards OR together; the stall lasts while any term holds.
- Reset values: state = IDLE, cnt = 0, md_busy = 0, md_done = 0. Reset mid-BUSY abandons the operation with no md_done pulse.
- Combinational outputs follow their inputs during reset.

Optional Feature:
- HAZARD_STATS_EN defined adds three outputs:
  - stall_cycles[31:0]: counts cycles with stall = 1.
  - load_use_cnt[31:0]: counts cycles with load_use = 1.
  - md_stall_cnt[31:0]: counts cycles with md_haz = 1.
- All three counters saturate at 0xFFFFFFFF and clear on rst.
- Without HAZARD_STATS_EN the ports and logic are absent and the stall behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - the md_state_t enum (IDLE, BUSY);
  - REG_ZERO = 5'd0;
  - the default MULT_CYCLES and DIV_CYCLES constants.
- One sub-module, md_busy_tracker, holds the FSM and counter and exports md_busy and md_done. The hazard equations stay in the top level.

Test Plan:
- Load-use on rt: mem_read_ex=1, reg_w_addr_ex=5, use_rt_id=1, rt_id=5 -> stall_pc, stall_if_id and bubble_id_ex all 1. Changing reg_w_addr_ex to 0 -> all 0.
- ID-branch operands:
  - branch_id=1, rs_id=8, reg_write_ex=1, reg_w_addr_ex=8 -> stall=1.
  - Same with EX idle, mem_read_mem=1, reg_w_addr_mem=8 -> stall=1.
  - Non-load MEM writer to 8 -> stall=0.
- Mult then mfhi: md_start_ex=1 with md_is_div_ex=0 at T and mfhilo_id=1 held -> stall at T..T+4, md_done=1 only at T+4, stall=0 at T+5.
- Div latency: md_start_ex=1 with md_is_div_ex=1 -> md_busy high for exactly 32 cycles, md_done a single pulse on the 32nd. A back-to-back md_id stalls until then.
- Reset mid-BUSY: rst at T+10 of a div -> next cycle md_busy=0, md_done never pulses, mfhilo_id no longer stalls.
- With HAZARD_STATS_EN: 3 load-use cycles plus 4 md cycles -> stall_cycles=7, load_use_cnt=3, md_stall_cnt=4. rst clears all three.
